polyshift_seq: RTL

- Sequential front-end that feeds the combinational right barrel shifter `polyshift_r`.
- Accepts right-shift requests whose shift amount may exceed WORD_WIDTH-1.
- Executes them as a sequence of passes, each of at most WORD_WIDTH-1 bits, through one `polyshift_r` instance.
- Presents the final word on a valid/ready output; sits between operand issue and the ALU writeback mux.

---
 rtl/shift_pkg.sv | 18 +
 rtl/polyshift_r.sv | 29 ++
 rtl/polyshift_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared shifter types: the shift-type encoding used by polyshift_r callers
// and the state encoding of the polyshift_seq pass sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    LOGIC            = 2'd0,
    ARITHMETIC       = 2'd1,
    DOUBLE_PRECISION = 2'd2,
    CYCLIC           = 2'd3
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/polyshift_r.sv
// Combinational right barrel shifter, shift amount 0..WORD_WIDTH-1.
// The word is extended on the left with the type's fill bits and then shifted.
module polyshift_r
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-2:0]         c_i,
  input  logic [WORD_WIDTH-1:0]         d_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
  input  shift_type_e                   shift_type_i,
  output logic [WORD_WIDTH-1:0]         d_o
);

  logic [2*WORD_WIDTH-2:0] ext;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    ext = {{(WORD_WIDTH-1){1'b0}}, d_i};
    unique case (shift_type_i)
      LOGIC:            ext = {{(WORD_WIDTH-1){1'b0}}, d_i};
      ARITHMETIC:       ext = {{(WORD_WIDTH-1){d_i[WORD_WIDTH-1]}}, d_i};
      DOUBLE_PRECISION: ext = {c_i, d_i};
      CYCLIC:           ext = {d_i[WORD_WIDTH-2:0], d_i};
    endcase
    d_o = WORD_WIDTH'(ext >> shift_size_i);
  end

endmodule

// File: rtl/polyshift_seq.sv
// Multi-pass right shifter: splits large shift amounts into passes of at most
// WORD_WIDTH-1 bits through one polyshift_r. POLYSHIFT_SEQ_FAST_EN shortcuts
// amounts whose result is known at accept time.
module polyshift_seq
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WORD_WIDTH-2:0]  c_i,
  input  logic [WORD_WIDTH-1:0]  d_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic [1:0]             shift_type_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WORD_WIDTH-1:0]  d_o,
  output logic                   busy_o
);

  localparam int                     SW       = $clog2(WORD_WIDTH);
  localparam logic [SHAMT_WIDTH-1:0] MAX_STEP = SHAMT_WIDTH'(WORD_WIDTH - 1);

  seq_state_e              state_q, state_d;
  logic [WORD_WIDTH-1:0]   d_q, d_d, sh_out;
  logic [WORD_WIDTH-2:0]   c_q, c_d;
  logic [SHAMT_WIDTH-1:0]  rem_q, rem_d, step;
  shift_type_e             type_q, type_d, type_in;

  assign type_in = shift_type_e'(shift_type_i);
  assign step    = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;

  polyshift_r #(.WORD_WIDTH(WORD_WIDTH)) u_shifter (
    .c_i          (c_q),
    .d_i          (d_q),
    .shift_size_i (step[SW-1:0]),
    .shift_type_i (type_q),
    .d_o          (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    c_d         = c_q;
    rem_d       = rem_q;
    type_d      = type_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          d_d     = d_i;
          c_d     = c_i;
          type_d  = type_in;
          rem_d   = shamt_i;
          state_d = (shamt_i != '0) ? SHIFT : DONE;
`ifdef POLYSHIFT_SEQ_FAST_EN
          if (type_in == CYCLIC) begin
            rem_d   = SHAMT_WIDTH'(int'(shamt_i) % WORD_WIDTH);
            state_d = (rem_d != '0) ? SHIFT : DONE;
          end else if (type_in != DOUBLE_PRECISION && int'(shamt_i) >= WORD_WIDTH) begin
            d_d     = (type_in == ARITHMETIC && d_i[WORD_WIDTH-1]) ? '1 : '0;
            rem_d   = '0;
            state_d = DONE;
          end else if (type_in == DOUBLE_PRECISION && int'(shamt_i) >= 2*WORD_WIDTH-1) begin
            d_d     = '0;
            c_d     = '0;
            rem_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        d_d   = sh_out;
        rem_d = rem_q - step;
        // Draining c alongside d keeps each pass equal to a slice of {c,d}.
        if (type_q == DOUBLE_PRECISION) c_d = c_q >> step;
        if (rem_q <= MAX_STEP) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register,
  // datapath included, is cleared by the async reset so d_o is defined.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      d_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      type_q  <= LOGIC;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
    end
  end

  assign d_o    = d_q;
  assign busy_o = (state_q != IDLE);

endmodule
